keypad_scan_encoder: RTL



---
 rtl/keypad_scan_encoder_pkg.sv | 49 ++++
 rtl/keypad_scan_encoder_if.sv | 27 ++
 rtl/keypad_scan_encoder_row_sync.sv | 34 +++
 rtl/keypad_scan_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_encoder_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 keypad scanner.
//   state_e     : scanner FSM states
//   row_hit_t   : result of decoding one synchronised row sample
//   ROW_IDLE    : row pattern with no key pressed (rows are pulled up)
//   COL_RESET   : column drive after reset (column 0 driven low)
//   KEY_*       : named key codes used by the vending-machine controller
//   decode_row  : one-cold row sample -> {valid, row index}
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    HOLD     = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } row_hit_t;

  localparam logic [3:0] ROW_IDLE  = 4'hF;
  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam logic [3:0] KEY_START   = 4'hF;
  localparam logic [3:0] KEY_OK      = 4'hC;
  localparam logic [3:0] KEY_CONFIRM = 4'hD;
  localparam logic [3:0] KEY_NEXT    = 4'hE;

  // Exactly one low row bit is a usable hit; idle and multi-key (ghost)
  // patterns both come back as not valid.
  function automatic row_hit_t decode_row(input logic [3:0] rs);
    row_hit_t hit;
    hit.valid = 1'b0;
    hit.idx   = 2'd0;
    case (rs)
      4'b1110: begin hit.valid = 1'b1; hit.idx = 2'd0; end
      4'b1101: begin hit.valid = 1'b1; hit.idx = 2'd1; end
      4'b1011: begin hit.valid = 1'b1; hit.idx = 2'd2; end
      4'b0111: begin hit.valid = 1'b1; hit.idx = 2'd3; end
      default: begin hit.valid = 1'b0; hit.idx = 2'd0; end
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_encoder_if
// Key-event interface between the keypad scanner (master, producer) and the
// vending-machine controller (slave, consumer).
//   key_value : code of the last accepted key, held until the next one
//   key_valid : one-cycle strobe when key_value is updated
//   key_down  : high from acceptance until the release is debounced
// -----------------------------------------------------------------------------
interface keypad_scan_encoder_if;

  logic [3:0] key_value;
  logic       key_valid;
  logic       key_down;

  modport master (
    output key_value,
    output key_valid,
    output key_down
  );

  modport slave (
    input key_value,
    input key_valid,
    input key_down
  );

endinterface

// File: rtl/keypad_scan_encoder_row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
// Two-flop synchroniser for the asynchronous keypad rows.
//   clk   : system clock
//   reset : asynchronous active-low reset (flops return to "no key")
//   row   : raw active-low row inputs
//   rs    : synchronised rows
// -----------------------------------------------------------------------------
module row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] rs
);

  logic [3:0] meta_r;
  logic [3:0] sync_r;

  // Two-stage capture of the row pins; resets to the idle (all released) pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= ROW_IDLE;
      sync_r <= ROW_IDLE;
    end else begin
      meta_r <= row;
      sync_r <= meta_r;
    end
  end

  assign rs = sync_r;

endmodule

// File: rtl/keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_encoder
// Scans a 4x4 active-low membrane keypad, debounces presses and releases, and
// emits one key event per press.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   row       : keypad rows, active-low, asynchronous to clk
//   shift_col : one-cold active-low column drive
//   key_if    : key-event master port (key_value / key_valid / key_down)
// Parameters:
//   SCAN_DIV       : clk cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS : matching samples needed to accept a press or release (>= 1)
// -----------------------------------------------------------------------------
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   row,
  output logic [3:0]                   shift_col,
  keypad_scan_encoder_if.master        key_if
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CW-1:0] DWELL_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_TARGET = MW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] DWELL_ONE    = CW'(1);
  localparam logic [MW-1:0] CNT_ONE      = MW'(1);
  localparam logic [MW-1:0] CNT_ZERO     = MW'(0);

  logic [3:0]    rs_s;
  row_hit_t      hit_s;
  logic          tick_s;
  logic          idle_s;

  logic [CW-1:0] dwell_r;
  state_e        state_r;
  logic [1:0]    col_idx_r;
  logic [3:0]    shift_col_r;
  logic [1:0]    cand_row_r;
  logic [MW-1:0] match_cnt_r;
  logic [MW-1:0] rel_cnt_r;
  logic [3:0]    key_value_r;
  logic          key_valid_r;
  logic          key_down_r;

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .rs    (rs_s)
  );

  // Sample tick at the end of each dwell, plus decode of the synchronised rows.
  always_comb begin
    tick_s = (dwell_r == DWELL_LAST);
    hit_s  = decode_row(rs_s);
    idle_s = (rs_s == ROW_IDLE);
  end

  // Dwell counter. The column only ever moves on a tick, so wrapping on the
  // tick also restarts the count for every newly driven column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_r <= '0;
    end else if (tick_s) begin
      dwell_r <= '0;
    end else begin
      dwell_r <= dwell_r + DWELL_ONE;
    end
  end

  // Scanner FSM with registered column drive and key-event outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      shift_col_r <= COL_RESET;
      cand_row_r  <= 2'd0;
      match_cnt_r <= CNT_ZERO;
      rel_cnt_r   <= CNT_ZERO;
      key_value_r <= 4'h0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
    end else begin
      // Strobe is a single cycle; only ACCEPT raises it.
      key_valid_r <= 1'b0;
      case (state_r)
        SCAN: begin
          if (tick_s) begin
            if (hit_s.valid) begin
              cand_row_r  <= hit_s.idx;
              match_cnt_r <= CNT_ONE;
              // A single required sample means the detecting tick already suffices.
              state_r     <= (DEBOUNCE_SCANS == 1) ? ACCEPT : DEBOUNCE;
            end else begin
              col_idx_r   <= col_idx_r + 2'd1;
              shift_col_r <= {shift_col_r[2:0], shift_col_r[3]};
            end
          end
        end
        DEBOUNCE: begin
          if (tick_s) begin
            if (hit_s.valid && (hit_s.idx == cand_row_r)) begin
              match_cnt_r <= match_cnt_r + CNT_ONE;
              if ((match_cnt_r + CNT_ONE) == MATCH_TARGET) begin
                state_r <= ACCEPT;
              end
            end else begin
              // Bounce, release or ghost: abandon the candidate and move on.
              match_cnt_r <= CNT_ZERO;
              col_idx_r   <= col_idx_r + 2'd1;
              shift_col_r <= {shift_col_r[2:0], shift_col_r[3]};
              state_r     <= SCAN;
            end
          end
        end
        ACCEPT: begin
          key_value_r <= {cand_row_r, col_idx_r};
          key_valid_r <= 1'b1;
          key_down_r  <= 1'b1;
          rel_cnt_r   <= CNT_ZERO;
          state_r     <= HOLD;
        end
        HOLD: begin
          // Column stays on the held key; other columns are not looked at
          // until the release is confirmed, so no auto-repeat or rollover.
          if (tick_s) begin
            if (idle_s) begin
              if ((rel_cnt_r + CNT_ONE) == MATCH_TARGET) begin
                rel_cnt_r   <= CNT_ZERO;
                match_cnt_r <= CNT_ZERO;
                key_down_r  <= 1'b0;
                col_idx_r   <= col_idx_r + 2'd1;
                shift_col_r <= {shift_col_r[2:0], shift_col_r[3]};
                state_r     <= SCAN;
              end else begin
                rel_cnt_r <= rel_cnt_r + CNT_ONE;
              end
            end else begin
              rel_cnt_r <= CNT_ZERO;
            end
          end
        end
        default: begin
          state_r     <= SCAN;
          col_idx_r   <= 2'd0;
          shift_col_r <= COL_RESET;
          match_cnt_r <= CNT_ZERO;
          rel_cnt_r   <= CNT_ZERO;
          key_down_r  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_col        = shift_col_r;
  assign key_if.key_value = key_value_r;
  assign key_if.key_valid = key_valid_r;
  assign key_if.key_down  = key_down_r;

endmodule
